// File: rtl/button_accumulator.sv
// button_accumulator: synchronises a debounced push-button, detects its
// falling edge and on each edge adds or subtracts an operand to a WIDTH-bit
// accumulator (wrap or saturate). It also reports a value window, keeps a
// sticky overflow flag and counts accepted presses.
module button_accumulator #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NUM_W    = 2,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned WIN_LO   = 1,
  parameter int unsigned WIN_HI   = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             button_stable,
  input  logic [NUM_W-1:0] num,
  input  logic             sub,
  input  logic             clear,
  output logic [WIDTH-1:0] accumulated_value,
  output logic             signal_out,
  output logic             update_pulse,
  output logic             overflow,
  output logic [CNT_W-1:0] press_count
);

  // Window bounds widened by one bit so the upper compare never folds to a
  // constant when WIN_HI is the largest representable value.
  localparam logic [WIDTH:0] LO_X = WIN_LO[WIDTH:0];
  localparam logic [WIDTH:0] HI_X = WIN_HI[WIDTH:0];

  // Raw add/subtract on WIDTH+1 bits; returns {carry_or_borrow, wrapped sum}.
  function automatic logic [WIDTH:0] accumulate(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH:0]   opd,
                                                input logic             do_sub);
    logic [WIDTH:0] t;
    logic           ovf;
    if (do_sub) begin
      t   = {1'b0, acc} - opd;
      ovf = ({1'b0, acc} < opd);
    end else begin
      t   = {1'b0, acc} + opd;
      ovf = t[WIDTH];
    end
    return {ovf, t[WIDTH-1:0]};
  endfunction

  // Clamp to the rail that was crossed when saturation is enabled.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                input logic             ovf,
                                                input logic             do_sub);
    logic [WIDTH-1:0] res;
    res = wrapped;
    if ((SATURATE != 0) && ovf) begin
      res = do_sub ? '0 : '1;
    end
    return res;
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic             s1_d, s2_d, s3_d;
  logic             fall;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic [WIDTH:0]   num_x;
  logic [WIDTH:0]   step_res;
  logic             step_ovf;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH:0]   acc_x;
  logic             in_lo, in_hi;

  // Synchroniser chain and falling-edge detect (s3 still high, s2 already low).
  always_comb begin
    s1_d = button_stable;
    s2_d = s1_q;
    s3_d = s2_q;
    fall = s3_q & ~s2_q;
  end

  // Next-value arithmetic for the pending event; num is zero-extended.
  always_comb begin
    num_x            = '0;
    num_x[NUM_W-1:0] = num;
    step_res         = accumulate(acc_q, num_x, sub);
    step_ovf         = step_res[WIDTH];
    step_val         = saturate(step_res[WIDTH-1:0], step_ovf, sub);
  end

  // Accumulator/overflow/counter update; clear beats a coincident event.
  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (fall) begin
      acc_d   = step_val;
      ovf_d   = ovf_q | step_ovf;
      cnt_d   = cnt_q + CNT_W'(1);
      pulse_d = 1'b1;
    end
  end

  // State registers; every flop returns to zero on reset, so a button held
  // low through reset cannot fake an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Window compare on the registered value, no added latency.
  assign acc_x = {1'b0, acc_q};
  generate
    if (WIN_LO == 0) begin : g_lo_open
      assign in_lo = 1'b1;
    end else begin : g_lo_cmp
      assign in_lo = (acc_x >= LO_X);
    end
  endgenerate
  assign in_hi = (acc_x <= HI_X);

  assign accumulated_value = acc_q;
  assign signal_out        = in_lo & in_hi;
  assign update_pulse      = pulse_q;
  assign overflow          = ovf_q;
  assign press_count       = cnt_q;

endmodule

// File: tb/tb_button_accumulator.sv
// Bench for button_accumulator: one wrapping and one saturating instance,
// scoreboard queues filled by the stimulus and drained by a pulse monitor.
module tb_button_accumulator;

  typedef struct packed {
    logic [3:0] acc;
    logic       ovf;
    logic [7:0] cnt;
    logic       sig;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       btn_w, btn_s;
  logic [1:0] num_w, num_s;
  logic       sub_w, sub_s;
  logic       clr_w, clr_s;
  logic [3:0] acc_w, acc_s;
  logic       sig_w, sig_s;
  logic       pulse_w, pulse_s;
  logic       ovf_w, ovf_s;
  logic [7:0] cnt_w, cnt_s;

  exp_t q_w[$];
  exp_t q_s[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  button_accumulator #(.WIDTH(4), .NUM_W(2), .SATURATE(0), .WIN_LO(1), .WIN_HI(2), .CNT_W(8)) dut_w (
    .clk(clk), .reset_n(rst_n), .button_stable(btn_w), .num(num_w), .sub(sub_w),
    .clear(clr_w), .accumulated_value(acc_w), .signal_out(sig_w),
    .update_pulse(pulse_w), .overflow(ovf_w), .press_count(cnt_w));

  button_accumulator #(.WIDTH(4), .NUM_W(2), .SATURATE(1), .WIN_LO(1), .WIN_HI(2), .CNT_W(8)) dut_s (
    .clk(clk), .reset_n(rst_n), .button_stable(btn_s), .num(num_s), .sub(sub_s),
    .clear(clr_s), .accumulated_value(acc_s), .signal_out(sig_s),
    .update_pulse(pulse_s), .overflow(ovf_s), .press_count(cnt_s));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full press: low for 4 cycles (covers E0..E2), then high for 3.
  task automatic press(input bit sat, input logic [1:0] n, input logic s, input exp_t e);
    if (sat) begin
      q_s.push_back(e); num_s = n; sub_s = s; btn_s = 1'b0;
    end else begin
      q_w.push_back(e); num_w = n; sub_w = s; btn_w = 1'b0;
    end
    step(4);
    if (sat) btn_s = 1'b1; else btn_w = 1'b1;
    step(3);
  endtask

  // Monitor: each update_pulse pops one expectation; pulses must be 1 cycle.
  logic prev_w = 1'b0, prev_s = 1'b0;
  exp_t ew, es;
  always @(negedge clk) begin
    if (pulse_w) begin
      check("wrap pulse width", prev_w, 1'b0);
      if (q_w.size() == 0) begin
        check("wrap unexpected pulse", 1, 0);
      end else begin
        ew = q_w.pop_front();
        check("wrap acc", acc_w, ew.acc);
        check("wrap ovf", ovf_w, ew.ovf);
        check("wrap cnt", cnt_w, ew.cnt);
        check("wrap sig", sig_w, ew.sig);
      end
    end
    if (pulse_s) begin
      check("sat pulse width", prev_s, 1'b0);
      if (q_s.size() == 0) begin
        check("sat unexpected pulse", 1, 0);
      end else begin
        es = q_s.pop_front();
        check("sat acc", acc_s, es.acc);
        check("sat ovf", ovf_s, es.ovf);
        check("sat cnt", cnt_s, es.cnt);
        check("sat sig", sig_s, es.sig);
      end
    end
    prev_w = pulse_w;
    prev_s = pulse_s;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    btn_w = 1'b0; btn_s = 1'b0;
    num_w = '0; num_s = '0; sub_w = 1'b0; sub_s = 1'b0;
    clr_w = 1'b0; clr_s = 1'b0;

    // Reset with the buttons held low.
    step(3);
    check("rst acc_w", acc_w, 0);
    check("rst cnt_w", cnt_w, 0);
    check("rst ovf_w", ovf_w, 0);
    check("rst pulse_w", pulse_w, 0);
    check("rst sig_w", sig_w, 0);
    check("rst acc_s", acc_s, 0);
    check("rst cnt_s", cnt_s, 0);
    rst_n = 1'b1;
    step(4);
    check("post-rst acc_w", acc_w, 0);
    check("post-rst cnt_w", cnt_w, 0);
    check("post-rst sig_w", sig_w, 0);
    check("post-rst pulse_w", pulse_w, 0);
    btn_w = 1'b1; btn_s = 1'b1;
    step(4);
    check("rising ignored cnt_w", cnt_w, 0);
    check("rising ignored cnt_s", cnt_s, 0);

    // Wrap adds: 3,6,9,12,15,2 with overflow on the sixth.
    press(0, 2'd3, 1'b0, '{acc: 4'd3,  ovf: 1'b0, cnt: 8'd1, sig: 1'b0});
    press(0, 2'd3, 1'b0, '{acc: 4'd6,  ovf: 1'b0, cnt: 8'd2, sig: 1'b0});
    press(0, 2'd3, 1'b0, '{acc: 4'd9,  ovf: 1'b0, cnt: 8'd3, sig: 1'b0});
    press(0, 2'd3, 1'b0, '{acc: 4'd12, ovf: 1'b0, cnt: 8'd4, sig: 1'b0});
    press(0, 2'd3, 1'b0, '{acc: 4'd15, ovf: 1'b0, cnt: 8'd5, sig: 1'b0});
    press(0, 2'd3, 1'b0, '{acc: 4'd2,  ovf: 1'b1, cnt: 8'd6, sig: 1'b1});

    // Saturate low, then add with overflow staying sticky.
    press(1, 2'd1, 1'b0, '{acc: 4'd1, ovf: 1'b0, cnt: 8'd1, sig: 1'b1});
    press(1, 2'd3, 1'b1, '{acc: 4'd0, ovf: 1'b1, cnt: 8'd2, sig: 1'b0});
    press(1, 2'd2, 1'b0, '{acc: 4'd2, ovf: 1'b1, cnt: 8'd3, sig: 1'b1});

    // Plain clear on the saturating instance.
    clr_s = 1'b1;
    step(1);
    clr_s = 1'b0;
    check("clr acc_s", acc_s, 0);
    check("clr ovf_s", ovf_s, 0);
    check("clr cnt_s kept", cnt_s, 3);

    // Build up to 14, then saturate high.
    press(1, 2'd3, 1'b0, '{acc: 4'd3,  ovf: 1'b0, cnt: 8'd4, sig: 1'b0});
    press(1, 2'd3, 1'b0, '{acc: 4'd6,  ovf: 1'b0, cnt: 8'd5, sig: 1'b0});
    press(1, 2'd3, 1'b0, '{acc: 4'd9,  ovf: 1'b0, cnt: 8'd6, sig: 1'b0});
    press(1, 2'd3, 1'b0, '{acc: 4'd12, ovf: 1'b0, cnt: 8'd7, sig: 1'b0});
    press(1, 2'd2, 1'b0, '{acc: 4'd14, ovf: 1'b0, cnt: 8'd8, sig: 1'b0});
    press(1, 2'd3, 1'b0, '{acc: 4'd15, ovf: 1'b1, cnt: 8'd9, sig: 1'b0});

    // Clear coincident with the fall cycle: clear wins, event dropped.
    num_w = 2'd1; sub_w = 1'b0;
    btn_w = 1'b0;
    step(2);
    clr_w = 1'b1;
    step(1);
    clr_w = 1'b0;
    check("collide acc_w", acc_w, 0);
    check("collide ovf_w", ovf_w, 0);
    check("collide cnt_w", cnt_w, 6);
    check("collide pulse_w", pulse_w, 0);
    step(1);
    btn_w = 1'b1;
    step(3);

    // Exact latency: nothing at E1, update visible right after E2.
    q_w.push_back('{acc: 4'd1, ovf: 1'b0, cnt: 8'd7, sig: 1'b1});
    num_w = 2'd1; sub_w = 1'b0;
    btn_w = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("E1 acc_w", acc_w, 0);
    check("E1 pulse_w", pulse_w, 0);
    @(posedge clk); #1;
    check("E2 acc_w", acc_w, 1);
    check("E2 pulse_w", pulse_w, 1);
    check("E2 cnt_w", cnt_w, 7);
    @(negedge clk);
    btn_w = 1'b1;
    step(3);

    // num = 0 is accepted and never overflows.
    press(0, 2'd0, 1'b1, '{acc: 4'd1, ovf: 1'b0, cnt: 8'd8, sig: 1'b1});

    // Reset between E0 and E2 loses the event.
    num_w = 2'd3; sub_w = 1'b0;
    btn_w = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid-rst acc_w", acc_w, 0);
    check("mid-rst cnt_w", cnt_w, 0);
    check("mid-rst cnt_s", cnt_s, 0);
    check("mid-rst ovf_s", ovf_s, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("after mid-rst acc_w", acc_w, 0);
    check("after mid-rst cnt_w", cnt_w, 0);
    check("after mid-rst pulse_w", pulse_w, 0);
    btn_w = 1'b1;
    step(3);
    press(0, 2'd2, 1'b0, '{acc: 4'd2, ovf: 1'b0, cnt: 8'd1, sig: 1'b1});

    step(5);
    check("wrap queue drained", q_w.size(), 0);
    check("sat queue drained", q_s.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_accumulator.md
# button_accumulator

Parametrised, clocked successor to the push-button accumulator used on the FPGA controller board. It samples a debounced button in the system clock domain, detects its falling edge, and on each edge adds or subtracts an operand to a WIDTH-bit accumulator with selectable wrap or saturate arithmetic. It flags when the value lies inside a configurable window, keeps a sticky overflow flag and counts accepted presses. It sits between the debouncer and the display/LED logic.

## Interface
- WIDTH, 4: accumulator width in bits; must be at least 2.
- NUM_W, 2: operand width; NUM_W ≤ WIDTH.
- SATURATE, 0: 0 selects modulo wrap; 1 clamps at 0 and 2^WIDTH−1.
- WIN_LO, 1: lower bound of the signal window, inclusive.
- WIN_HI, 2: upper bound of the signal window, inclusive; WIN_LO ≤ WIN_HI < 2^WIDTH.
- CNT_W, 8: press counter width.
- clk  in  1  system clock; all state is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- button_stable  in  1  debounced button level, asynchronous to clk.
- num  in  NUM_W  operand, unsigned; sampled in the update cycle.
- sub  in  1  1 subtracts num, 0 adds num; sampled in the update cycle.
- clear  in  1  synchronous clear of the accumulator and overflow.
- accumulated_value  out  WIDTH  current accumulator value.
- signal_out  out  1  1 when WIN_LO ≤ accumulated_value ≤ WIN_HI.
- update_pulse  out  1  one-cycle pulse that marks a new accumulated value.
- overflow  out  1  sticky carry/borrow/clamp flag.
- press_count  out  CNT_W  count of accepted button events.

## Operation
- **Synchroniser.** A three-flop chain s1→s2→s3 samples button_stable. Every flop resets to 0, so a button held low during reset never produces an event.
- **Event.** fall = s3 & ~s2: one cycle per falling edge of button_stable. Rising edges are ignored.
- **Arithmetic.**
  - num is zero-extended to WIDTH+1 bits.
  - t = acc + num when sub = 0; t = acc − num when sub = 1.
  - Carry: t[WIDTH] set on add. Borrow: acc < num on subtract.
- **Wrap mode (SATURATE = 0).** acc ← t[WIDTH-1:0]. Carry or borrow sets overflow.
- **Saturate mode (SATURATE = 1).** On carry acc ← 2^WIDTH−1; on borrow acc ← 0. Either case sets overflow.
- **Accepted event.** Each event also updates press_count ← press_count+1, wrapping mod 2^CNT_W, and pulses update_pulse for one cycle. Events that overflow still count.
- **Clear.**
  - acc ← 0 and overflow ← 0.
  - press_count is not cleared.
  - update_pulse is not asserted.
- **Simultaneous clear and fall.** clear wins and the event is discarded: press_count is not incremented and no pulse is issued.
- **Overflow.** Once set, overflow stays high until clear or reset. num = 0 events are accepted, count, and never overflow.
- **signal_out.** Combinational compare on the registered acc; it carries no extra latency.
- **Reset.**
  - accumulated_value = 0 and press_count = 0.
  - overflow = 0 and update_pulse = 0.
  - signal_out = (WIN_LO == 0).
- **Reset mid-operation.** Asserting reset_n low at any time returns the block to the reset state immediately, and an event in flight is lost.

## Timing
- **Event latency.** Let E0 be the first rising clk edge at which button_stable = 0 is captured after having been 1.
  - E1: fall is high.
  - E2: accumulated_value, overflow and press_count update, and update_pulse is high for the cycle after E2.
  - Latency is therefore 3 edges from capture.
- **Operand sampling.** num and sub are sampled at E2, and must be stable from E1 to E2.
- **Minimum spacing.** button_stable must be low ≥ 1 clk and high ≥ 1 clk between events. Pulses shorter than one clock may be missed.
- **clear latency.** clear is registered: it takes effect on the next rising edge.
- **Reset release.** reset_n release is expected to be synchronous to clk externally. The first event can be detected 2 edges after release.

## Test plan
1. **Reset and window.** Reset with button_stable held low, then release → no update_pulse, acc=0, press_count=0, signal_out=0.
2. **Add sequence (wrap, WIDTH=4).** num=3, sub=0, six falling edges → acc goes 3,6,9,12,15,2. overflow rises on the 6th event; press_count=6; signal_out=1 only at acc=2.
3. **Subtract and saturate.** SATURATE=1, acc=1, sub=1, num=3 → acc=0, overflow=1. Then num=2, sub=0 → acc=2, overflow stays 1.
4. **Saturate high.** SATURATE=1, acc=14, num=3 add → acc=15, overflow=1, update_pulse for 1 cycle.
5. **Clear collision.** clear asserted in the same cycle as fall → acc=0, overflow=0, press_count unchanged, no update_pulse.
6. **Latency and reset mid-flight.** Drop button_stable, then assert reset_n between E0 and E2 → acc stays 0 and press_count stays 0. Without the reset, the update appears exactly at E2.
